// File: rtl/reg_file_32x32.sv
// reg_file_32x32: 32x32 register file, two combinational read ports, one clocked write
// port, a debug read port that is never bypassed, and a committed-write counter.
module reg_file_32x32 #(
   parameter int DW     = 32,
   parameter int AW     = 5,
   parameter int BYPASS = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] ra1,
   input  logic [AW-1:0] ra2,
   output logic [DW-1:0] rd1,
   output logic [DW-1:0] rd2,
   input  logic          we,
   input  logic [AW-1:0] wa,
   input  logic [DW-1:0] wd,
   input  logic [AW-1:0] dbg_a,
   output logic [DW-1:0] dbg_d,
   output logic [15:0]   wr_cnt
);
   logic [DW-1:0] r_mem [0:2**AW-1];
   logic [15:0]   r_wr_cnt;
   logic          w_wr;
   logic [DW-1:0] w_rd1;
   logic [DW-1:0] w_rd2;

   // an X on we fails the if-test below, so it behaves as no write
   assign w_wr = we && (wa != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2**AW; i++) r_mem[i] <= '0;
         r_wr_cnt <= '0;
      end else if (w_wr) begin
         r_mem[wa] <= wd;
         r_wr_cnt  <= r_wr_cnt + 16'd1;
      end
   end

   assign w_rd1  = (ra1 == '0) ? '0 : r_mem[ra1];
   assign w_rd2  = (ra2 == '0) ? '0 : r_mem[ra2];
   // w_wr already excludes wa==0, so a bypass hit can never expose $0
   assign rd1    = (BYPASS != 0 && w_wr && ra1 == wa) ? wd : w_rd1;
   assign rd2    = (BYPASS != 0 && w_wr && ra2 == wa) ? wd : w_rd2;
   assign dbg_d  = (dbg_a == '0) ? '0 : r_mem[dbg_a];
   assign wr_cnt = r_wr_cnt;
endmodule

// File: tb/tb_reg_file_32x32.sv
// tb_reg_file_32x32: directed vectors into a scoreboard queue; a monitor process pops
// and compares whenever the stimulus strobes a sample point.
module tb_reg_file_32x32;
   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  ra1, ra2, wa, dbg_a;
   logic        we;
   logic [31:0] wd;
   logic [31:0] rd1, rd2, dbg_d, rd1_0, rd2_0, dbg_d_0;
   logic [15:0] wr_cnt, wr_cnt_0;
   logic        alu_src;
   logic [31:0] imm, mux_y;
   logic [15:0] exp_cnt;
   int          total = 0;
   int          bad = 0;

   typedef struct {
      string       n;
      int          s;
      logic [31:0] e;
   } exp_t;
   exp_t q[$];
   event smp;

   always #5 clk = ~clk;

   reg_file_32x32 #(.DW(32), .AW(5), .BYPASS(1)) dut (
      .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
      .we(we), .wa(wa), .wd(wd), .dbg_a(dbg_a), .dbg_d(dbg_d), .wr_cnt(wr_cnt)
   );

   reg_file_32x32 #(.DW(32), .AW(5), .BYPASS(0)) dut0 (
      .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1_0), .rd2(rd2_0),
      .we(we), .wa(wa), .wd(wd), .dbg_a(dbg_a), .dbg_d(dbg_d_0), .wr_cnt(wr_cnt_0)
   );

   // downstream ALU-source mux: A = rd2, B = sign-extended immediate
   assign mux_y = alu_src ? imm : rd2;

   function automatic logic [31:0] act(int s);
      case (s)
         0:       return rd1;
         1:       return rd2;
         2:       return dbg_d;
         3:       return {16'h0, wr_cnt};
         4:       return rd1_0;
         5:       return rd2_0;
         6:       return mux_y;
         default: return {16'h0, wr_cnt_0};
      endcase
   endfunction

   initial forever begin
      @(smp);
      #1;
      while (q.size() > 0) begin
         exp_t x;
         logic [31:0] a;
         x = q.pop_front();
         a = act(x.s);
         total++;
         if (a !== x.e) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", x.n, a, x.e);
         end
      end
   end

   always @(posedge clk)
      if ($isunknown(we)) begin
         bad++;
         $display("FAIL we_x: got %b expected 0 or 1", we);
      end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(string n, int s, logic [31:0] e);
      q.push_back('{n, s, e});
   endtask

   task automatic sample();
      -> smp;
      #2;
   endtask

   task automatic write(logic [4:0] a, logic [31:0] d);
      @(negedge clk);
      we = 1'b1;
      wa = a;
      wd = d;
      @(negedge clk);
      we = 1'b0;
      if (a != 5'd0) exp_cnt = exp_cnt + 16'd1;
   endtask

   initial begin
      rst = 1'b1; we = 1'b0; wa = '0; wd = '0;
      ra1 = 5'd9; ra2 = 5'd9; dbg_a = 5'd9;
      alu_src = 1'b0; imm = 32'hFFFF_FFF6;
      exp_cnt = '0;
      // reset held for 20 ns with the clock running
      #18;
      chk("rst_cnt", 3, 32'h0);
      chk("rst_rd1", 0, 32'h0);
      sample();
      @(negedge clk);
      rst = 1'b0;
      for (int a = 0; a < 32; a++) begin
         ra1 = 5'(a); ra2 = 5'(a); dbg_a = 5'(a);
         chk("rst_rd1", 0, 32'h0);
         chk("rst_rd2", 1, 32'h0);
         chk("rst_dbg", 2, 32'h0);
         sample();
      end
      chk("rst_cnt_after", 3, 32'h0);
      sample();

      // basic write/read, rd2 through the ALU-source mux
      write(5'd5, 32'h00FF00FF);
      write(5'd6, 32'hFF00FF00);
      ra1 = 5'd5; ra2 = 5'd6;
      chk("basic_rd1", 0, 32'h00FF00FF);
      chk("basic_rd2", 1, 32'hFF00FF00);
      chk("basic_cnt", 3, 32'd2);
      chk("basic_mux_a", 6, 32'hFF00FF00);
      sample();
      alu_src = 1'b1;
      chk("basic_mux_b", 6, 32'hFFFF_FFF6);
      sample();
      alu_src = 1'b0;

      // $0 write attempt
      @(negedge clk);
      we = 1'b1; wa = 5'd0; wd = 32'hDEADBEEF; ra1 = 5'd0; dbg_a = 5'd0;
      chk("r0_pre_rd1", 0, 32'h0);
      chk("r0_pre_rd1_nb", 4, 32'h0);
      sample();
      @(negedge clk);
      chk("r0_post_rd1", 0, 32'h0);
      chk("r0_post_dbg", 2, 32'h0);
      chk("r0_cnt", 3, 32'd2);
      sample();
      we = 1'b0;

      // bypass on the same-address write, plain storage on the BYPASS=0 copy
      write(5'd7, 32'h11111111);
      @(negedge clk);
      ra1 = 5'd7; ra2 = 5'd7; dbg_a = 5'd7;
      we = 1'b1; wa = 5'd7; wd = 32'h22222222;
      chk("byp_rd1", 0, 32'h22222222);
      chk("byp_rd2", 1, 32'h22222222);
      chk("byp_dbg_pre", 2, 32'h11111111);
      chk("nobyp_rd1_pre", 4, 32'h11111111);
      chk("nobyp_rd2_pre", 5, 32'h11111111);
      sample();
      ra2 = 5'd6;
      chk("byp_other_addr", 1, 32'hFF00FF00);
      sample();
      ra2 = 5'd7;
      @(posedge clk);
      #1;
      we = 1'b0;
      exp_cnt = exp_cnt + 16'd1;
      chk("byp_dbg_post", 2, 32'h22222222);
      chk("byp_rd1_post", 0, 32'h22222222);
      chk("nobyp_rd1_post", 4, 32'h22222222);
      chk("byp_cnt", 3, 32'(exp_cnt));
      sample();

      // asynchronous reset with a write pending to r4
      write(5'd3, 32'hA5A5A5A5);
      ra1 = 5'd3; ra2 = 5'd4; dbg_a = 5'd3;
      chk("ar_pre_r3", 0, 32'hA5A5A5A5);
      sample();
      @(negedge clk);
      we = 1'b1; wa = 5'd4; wd = 32'h44444444;
      #1;
      rst = 1'b1;
      exp_cnt = '0;
      chk("ar_rd1", 0, 32'h0);
      chk("ar_rd1_nb", 4, 32'h0);
      chk("ar_dbg", 2, 32'h0);
      chk("ar_cnt", 3, 32'h0);
      sample();
      @(posedge clk);
      #1;
      we = 1'b0;
      dbg_a = 5'd4;
      chk("ar_r4_held", 2, 32'h0);
      sample();
      rst = 1'b0;
      @(negedge clk);
      chk("ar_r4_after", 2, 32'h0);
      chk("ar_r3_after", 0, 32'h0);
      chk("ar_cnt_after", 3, 32'h0);
      chk("ar_cnt_after_nb", 7, 32'h0);
      sample();

      // full sweep
      for (int i = 1; i < 32; i++) write(5'(i), 32'(i) * 32'h01010101);
      for (int a = 0; a < 32; a++) begin
         dbg_a = 5'(a);
         chk("sweep_dbg", 2, 32'(a) * 32'h01010101);
         sample();
      end
      chk("sweep_cnt", 3, 32'd31);
      sample();

      // counter wrap: back-to-back writes up to 0xFFFF, then one more
      @(negedge clk);
      we = 1'b1; wa = 5'd1; wd = 32'h0BAD_F00D;
      repeat (65535 - 31) @(negedge clk);
      we = 1'b0;
      exp_cnt = 16'hFFFF;
      dbg_a = 5'd1;
      chk("wrap_pre", 3, 32'(exp_cnt));
      chk("wrap_r1", 2, 32'h0BAD_F00D);
      sample();
      write(5'd2, 32'h12345678);
      chk("wrap_cnt", 3, 32'(exp_cnt));
      chk("wrap_cnt_nb", 7, 32'(exp_cnt));
      sample();

      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: got %0d expected 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/reg_file_32x32.md
Name: reg_file_32x32

Overview:
- 32-entry x 32-bit general-purpose register file for the single-cycle CPU.
- Sits directly upstream of the ALU-source 32-bit 2:1 mux. Read port 1 feeds the ALU A operand. Read port 2 feeds the mux A input; the sign-extended immediate feeds the mux B input.
- Two combinational read ports, one clocked write port, and a third read port for debug/LED display.
- Register $0 is hardwired to zero; optional write-through bypass.

Parameters:
- DW, 32, data width in bits.
- AW, 5, address width (2^AW entries).
- BYPASS, 1: 1 means a read of the register being written this cycle returns the write data; 0 means it returns the stored value.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- ra1  input  AW  read address 1 (rs).
- ra2  input  AW  read address 2 (rt).
- rd1  output  DW  read data 1, to ALU A.
- rd2  output  DW  read data 2, to the ALU-source mux A input.
- we  input  1  write enable.
- wa  input  AW  write address (rd/rt selected upstream).
- wd  input  DW  write data (from the write-back mux).
- dbg_a  input  AW  debug read address.
- dbg_d  output  DW  debug read data; never bypassed.
- wr_cnt  output  16  count of committed writes, for bench and LED observation.

Behaviour:
- Reset:
  - While rst=1, all 32 entries and wr_cnt are 0 immediately; clock edges are ignored.
  - Deassertion takes effect at the next rising edge.
  - Reset asserted mid-write cancels that write.
- Write:
  - On the rising edge of clk, if we=1 and wa!=0, entry[wa] <= wd and wr_cnt <= wr_cnt+1.
  - Writes to wa=0 are discarded and do not increment wr_cnt.
  - wr_cnt wraps 0xFFFF -> 0x0000.
- Read:
  - rd1, rd2 and dbg_d are combinational from the addresses; there is no read latency.
  - Address 0 always reads 0, including under bypass.
- Bypass (BYPASS=1):
  - If we=1, wa!=0 and ra1==wa, then rd1=wd in the same cycle. rd2 uses the same rule with ra2.
  - dbg_d is never bypassed; it shows the stored value, which updates after the edge.
- Bypass (BYPASS=0): rd1 and rd2 show the old value until the edge, then the new value.
- Simultaneous events:
  - ra1==ra2==wa: both read ports obey the same bypass rule.
  - A read and a write to different addresses do not interact.
- Unknown inputs: X on we during a clock edge is treated as no write. The bench checks that X is never driven.
- Storage: no initial values other than those set by reset; there is no read-modify-write.

Test Plan:
1. Reset: assert rst for 20 ns with clk running. Every address read via ra1, ra2 and dbg_a returns 0x00000000, and wr_cnt=0.
2. Basic write/read:
   - Write 0x00FF00FF to r5 and 0xFF00FF00 to r6.
   - Set ra1=5, ra2=6 and apply rd2 to the downstream mux with B=imm.
   - Expect rd1=0x00FF00FF, rd2=0xFF00FF00, wr_cnt=2.
3. $0 protection: we=1, wa=0, wd=0xDEADBEEF. ra1=0 reads 0 both before and after the edge, and wr_cnt is unchanged.
4. Bypass:
   - With BYPASS=1, r7 holding 0x11111111, ra1=ra2=7, we=1, wa=7, wd=0x22222222.
   - rd1=rd2=0x22222222 before the edge; dbg_d(7)=0x11111111 until the edge, then 0x22222222.
   - With BYPASS=0, rd1=0x11111111 until the edge.
5. Asynchronous reset mid-operation:
   - r3=0xA5A5A5A5 and a write pending to r4.
   - Pulse rst high between clock edges: r3 reads 0 within the same timestep, the r4 write never lands, and wr_cnt=0.
6. Full sweep and wrap:
   - Write i*0x01010101 to r1..r31, then read all via dbg_a; each value matches and r0=0.
   - Preload wr_cnt to 0xFFFF via 65535 writes; one more write gives wr_cnt=0x0000.
